huffman_bit_packer: RTL

// - Downstream stage of the Huffman code generator. Captures the 6-entry code table (HCn/Mn) on code_valid.
// - Then accepts a stream of gray symbols (1..6) and emits each symbol's variable-length code MSB-first.
// - Packs the code bits into 8-bit bytes on a valid/ready output; the final partial byte is zero-padded and flagged.

---
 rtl/huffman_bit_packer_if.sv | 24 ++
 rtl/huffman_bit_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer_if.sv
// Symbol-in / byte-out stream bundle for huffman_bit_packer.
// Both channels transfer on a rising clk edge where valid && ready are both high; the sender
// holds valid and its payload stable until that edge, and ready may depend on internal state only.
`timescale 1ns/1ps
interface huffman_bit_packer_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] sym_data;
  logic       sym_last;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_last;

  modport master (
    output sym_valid, sym_data, sym_last, byte_ready,
    input  sym_ready, byte_valid, byte_data, byte_last
  );

  modport slave (
    input  sym_valid, sym_data, sym_last, byte_ready,
    output sym_ready, byte_valid, byte_data, byte_last
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: captures a 6-entry Huffman table and packs each symbol's code MSB-first
// into bytes. Define HUFF_PACK_STATS_EN to add the bit_count output.
`timescale 1ns/1ps
module huffman_bit_packer #(
  parameter int MAXLEN = 5,
  parameter int ACC_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [7:0]            HC1,
  input  logic [7:0]            HC2,
  input  logic [7:0]            HC3,
  input  logic [7:0]            HC4,
  input  logic [7:0]            HC5,
  input  logic [7:0]            HC6,
  input  logic [7:0]            M1,
  input  logic [7:0]            M2,
  input  logic [7:0]            M3,
  input  logic [7:0]            M4,
  input  logic [7:0]            M5,
  input  logic [7:0]            M6,
  huffman_bit_packer_if.slave   bus,
  output logic                  err,
  output logic [1:0]            state_dbg
`ifdef HUFF_PACK_STATS_EN
  ,
  output logic [15:0]           bit_count
`endif
);
  localparam int NSYM  = 6;
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ACC_W-1:0]    acc, acc_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [MAXLEN-1:0]   tbl_code [NSYM];
  logic [CNT_W-1:0]    tbl_len  [NSYM];
  logic [7:0]          hc_in    [NSYM];
  logic [7:0]          m_in     [NSYM];
  logic                unused_hi;

  logic                sym_in_range, sym_ok;
  logic [2:0]          sym_idx;
  logic [MAXLEN-1:0]   sel_code;
  logic [CNT_W-1:0]    sel_len;
  logic [ACC_W-1:0]    code_shifted;
  logic                sym_ready_c, byte_valid_c;
  logic                sym_hs, byte_hs;
  logic                load, err_set;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAXLEN-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAXLEN; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  always_comb begin
    hc_in[0] = HC1; hc_in[1] = HC2; hc_in[2] = HC3;
    hc_in[3] = HC4; hc_in[4] = HC5; hc_in[5] = HC6;
    m_in[0]  = M1;  m_in[1]  = M2;  m_in[2]  = M3;
    m_in[3]  = M4;  m_in[4]  = M5;  m_in[5]  = M6;
  end

  // Only the low MAXLEN bits of the code and mask carry information.
  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < NSYM; i++)
      unused_hi = unused_hi ^ (^hc_in[i][7:MAXLEN]) ^ (^m_in[i][7:MAXLEN]);
  end

  // Table stores the pre-masked code and its length so lookup is a plain read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) begin
        tbl_code[i] <= '0;
        tbl_len[i]  <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NSYM; i++) begin
        tbl_code[i] <= hc_in[i][MAXLEN-1:0] & m_in[i][MAXLEN-1:0];
        tbl_len[i]  <= popcount(m_in[i][MAXLEN-1:0]);
      end
    end
  end

  always_comb begin
    sym_in_range = (bus.sym_data != 8'd0) && (bus.sym_data <= 8'(NSYM));
    sym_idx      = bus.sym_data[2:0] - 3'd1;
    sel_code     = '0;
    sel_len      = '0;
    if (sym_in_range) begin
      sel_code = tbl_code[sym_idx];
      sel_len  = tbl_len[sym_idx];
    end
    sym_ok = sym_in_range && (sel_len != '0);
    // New code lands directly below the cnt bits already held at the top of acc.
    code_shifted = ACC_W'(sel_code) << (CNT_W'(ACC_W) - cnt - sel_len);
  end

  assign sym_ready_c  = (state == RUN) && (cnt < CNT_W'(8));
  assign byte_valid_c = (cnt >= CNT_W'(8)) || ((state == FLUSH) && (cnt != '0));
  assign sym_hs       = bus.sym_valid && sym_ready_c;
  assign byte_hs      = byte_valid_c && bus.byte_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    load     = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (code_valid) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (sym_hs) begin
          if (sym_ok) begin
            acc_nx = acc | code_shifted;
            cnt_nx = cnt + sel_len;
          end else begin
            err_set = 1'b1;
          end
          if (bus.sym_last) state_nx = FLUSH;
        end else if (code_valid && (cnt == '0)) begin
          load = 1'b1;
        end
        if (byte_hs) begin
          acc_nx = acc_nx << 8;
          cnt_nx = cnt_nx - CNT_W'(8);
        end
      end
      FLUSH: begin
        // An empty accumulator (illegal last symbol) returns without emitting anything.
        if (cnt == '0) begin
          state_nx = RUN;
        end else if (byte_hs) begin
          if (cnt <= CNT_W'(8)) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = RUN;
          end else begin
            acc_nx = acc << 8;
            cnt_nx = cnt - CNT_W'(8);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (load)    err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

`ifdef HUFF_PACK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                bit_count <= '0;
    else if (load)             bit_count <= '0;
    else if (sym_hs && sym_ok) bit_count <= bit_count + 16'(sel_len);
  end
`endif

  assign bus.sym_ready  = sym_ready_c;
  assign bus.byte_valid = byte_valid_c;
  assign bus.byte_data  = acc[ACC_W-1 -: 8];
  assign bus.byte_last  = (state == FLUSH) && (cnt != '0) && (cnt <= CNT_W'(8));
  assign state_dbg      = state;

endmodule
